uart_rx_core: RTL and testbench

Parametrised UART receiver: oversampled start-bit detection, mid-bit sampling, optional parity, 1 or 2 stop bits, LSB-first deserialisation. Completed characters go into a holding register with valid/ready handoff and per-character error flags. Sits between the pin synchroniser domain and the UART register/FIFO layer, driven by a shared baud-tick generator.

---
 rtl/uart_rx_core_if.sv | 49 ++++
 rtl/uart_rx_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// ----------------------------------------------------------------------------
// uart_rx_core_if
// Character hand-off bundle between the UART receiver core and its consumer
// (register block / receive FIFO).
//
//   rd_ready    consumer -> core   consumer takes dout this cycle
//   dout        core -> consumer   received character (DATA_BITS wide)
//   dout_valid  core -> consumer   holding register has an unread character
//   frame_err   core -> consumer   stop bit sampled low for the held character
//   parity_err  core -> consumer   parity mismatch for the held character
//   overrun     core -> consumer   one-clk pulse: completed character dropped
//   busy        core -> consumer   receiver is inside a frame
//
// modport master : the receiver core (drives the character side)
// modport slave  : the consumer (drives rd_ready)
// ----------------------------------------------------------------------------
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 rd_ready;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rd_ready,
        output dout,
        output dout_valid,
        output frame_err,
        output parity_err,
        output overrun,
        output busy
    );

    modport slave (
        output rd_ready,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// Oversampling UART receiver. Detects the start edge, re-checks the line in
// the middle of the start bit, then samples every following bit at its
// centre. Data arrives LSB first, is optionally followed by a parity bit and
// then 1 or 2 stop bits. Each finished character is placed in a one-deep
// holding register together with its error flags and handed to the consumer
// with a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   baud_tick  one-clk pulse at OVERSAMPLE x baud rate (shared generator)
//   rxd        raw serial line, idle high, asynchronous to clk
//   bus        uart_rx_core_if.master: rd_ready in; dout, dout_valid,
//              frame_err, parity_err, overrun, busy out (all registered)
//
// Parameters:
//   DATA_BITS   5..9 character length
//   OVERSAMPLE  even, >= 4, baud_tick pulses per bit period
//   PARITY_EN   1 = parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even
//   STOP_BITS   1 or 2 stop bits checked
// ----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  rxd,
    uart_rx_core_if.master        bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Start bit is re-checked half a bit after the edge; every later bit is
    // sampled a full bit period after the previous sample.
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity of a character (1 when it holds an odd number of ones).
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                 sync_meta_r;
    logic                 rs_r;
    state_t               state_r;
    logic [TW-1:0]        tick_r;
    logic [BW-1:0]        bit_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 perr_r;
    logic                 ferr_r;

    logic [DATA_BITS-1:0] dout_r;
    logic                 dout_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;
    logic                 busy_r;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    state_t               state_nxt_s;
    logic [TW-1:0]        tick_nxt_s;
    logic [BW-1:0]        bit_nxt_s;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic                 perr_nxt_s;
    logic                 ferr_nxt_s;
    logic                 done_s;
    logic                 done_ferr_s;
    logic                 read_s;
    logic                 tick_last_s;

    assign tick_last_s = (tick_r == TICK_LAST);
    assign read_s      = dout_valid_r & bus.rd_ready;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            rs_r        <= 1'b1;
        end else begin
            sync_meta_r <= rxd;
            rs_r        <= sync_meta_r;
        end
    end

    // Frame FSM next-state and datapath next-values.
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = tick_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        perr_nxt_s  = perr_r;
        ferr_nxt_s  = ferr_r;
        done_s      = 1'b0;
        done_ferr_s = ferr_r;

        case (state_r)
            ST_IDLE: begin
                // Edge detect runs on every clk, not only on ticks.
                if (rs_r == 1'b0) begin
                    state_nxt_s = ST_START;
                    tick_nxt_s  = TICK_ZERO;
                    bit_nxt_s   = BIT_ZERO;
                    perr_nxt_s  = 1'b0;
                    ferr_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    if (tick_r == TICK_MID) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        if (rs_r == 1'b1) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_DATA;
                            tick_nxt_s  = TICK_ZERO;
                            bit_nxt_s   = BIT_ZERO;
                        end
                    end else begin
                        tick_nxt_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_last_s) begin
                        tick_nxt_s = TICK_ZERO;
                        // LSB arrives first, so shifting right leaves bit 0
                        // at position 0 after the last data sample.
                        shift_nxt_s = {rs_r, shift_r[DATA_BITS-1:1]};
                        if (bit_r == DATA_LAST) begin
                            bit_nxt_s   = BIT_ZERO;
                            state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_nxt_s = bit_r + BIT_ONE;
                        end
                    end else begin
                        tick_nxt_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_last_s) begin
                        tick_nxt_s  = TICK_ZERO;
                        bit_nxt_s   = BIT_ZERO;
                        perr_nxt_s  = ((parity_of(shift_r) ^ rs_r) != PAR_ODD);
                        state_nxt_s = ST_STOP;
                    end else begin
                        tick_nxt_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end

            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_last_s) begin
                        tick_nxt_s = TICK_ZERO;
                        ferr_nxt_s = ferr_r | ~rs_r;
                        if (bit_r == STOP_LAST) begin
                            // Leave mid stop bit so the next start edge is
                            // caught without any dead time.
                            done_s      = 1'b1;
                            done_ferr_s = ferr_r | ~rs_r;
                            bit_nxt_s   = BIT_ZERO;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            bit_nxt_s = bit_r + BIT_ONE;
                        end
                    end else begin
                        tick_nxt_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                tick_nxt_s  = TICK_ZERO;
                bit_nxt_s   = BIT_ZERO;
            end
        endcase
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            tick_r  <= tick_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            perr_r  <= perr_nxt_s;
            ferr_r  <= ferr_nxt_s;
            // Taken from the next state so busy lines up with state_r.
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Holding register: load on completion, clear valid on read, flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r       <= {DATA_BITS{1'b0}};
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (done_s) begin
                // A read in the same cycle frees the slot for the new character.
                if (!dout_valid_r || read_s) begin
                    dout_r       <= shift_r;
                    frame_err_r  <= done_ferr_s;
                    parity_err_r <= perr_r;
                    dout_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (read_s) begin
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= dout_valid_r;
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.parity_err = parity_err_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Three receivers share clk/rst/baud_tick, each with its own serial line:
//   dut0 defaults (8N1), dut1 even parity (8E1), dut2 two stop bits (8N2).
// baud_tick pulses every second clk, so one bit period is 32 clks.
// Expected characters are queued when a frame is driven and compared when the
// receiver presents it.
// ----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int BIT_CLKS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        baud_tick = 1'b0;
    int unsigned cyc = 0;

    logic        rxd_m  [3];
    logic        rd_m   [3];
    logic [7:0]  dout_m [3];
    logic        dv_m   [3];
    logic        fe_m   [3];
    logic        pe_m   [3];
    logic        ov_m   [3];
    logic        busy_m [3];

    int          vectors = 0;
    int          miscompares = 0;
    int          ov_cnt [3] = '{0, 0, 0};
    int unsigned ov_cyc [3] = '{0, 0, 0};

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];

    uart_rx_core_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_core_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_core_if #(.DATA_BITS(8)) bus2 ();

    uart_rx_core dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_m[0]), .bus(bus0)
    );

    uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_m[1]), .bus(bus1)
    );

    uart_rx_core #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_m[2]), .bus(bus2)
    );

    assign bus0.rd_ready = rd_m[0];
    assign bus1.rd_ready = rd_m[1];
    assign bus2.rd_ready = rd_m[2];
    assign dout_m[0] = bus0.dout;  assign dv_m[0] = bus0.dout_valid;
    assign dout_m[1] = bus1.dout;  assign dv_m[1] = bus1.dout_valid;
    assign dout_m[2] = bus2.dout;  assign dv_m[2] = bus2.dout_valid;
    assign fe_m[0] = bus0.frame_err;  assign pe_m[0] = bus0.parity_err;
    assign fe_m[1] = bus1.frame_err;  assign pe_m[1] = bus1.parity_err;
    assign fe_m[2] = bus2.frame_err;  assign pe_m[2] = bus2.parity_err;
    assign ov_m[0] = bus0.overrun;  assign busy_m[0] = bus0.busy;
    assign ov_m[1] = bus1.overrun;  assign busy_m[1] = bus1.busy;
    assign ov_m[2] = bus2.overrun;  assign busy_m[2] = bus2.busy;

    // Clock and posedge counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick every second clk, changed on the falling edge.
    always @(negedge clk) baud_tick <= (cyc[0] == 1'b0);

    // Count overrun-high cycles and remember when the last one was seen.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov_m[i] === 1'b1) begin
                ov_cnt[i] <= ov_cnt[i] + 1;
                ov_cyc[i] <= cyc;
            end
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        @(negedge clk);
        while (cyc[0] != 1'b0) @(negedge clk);
    endtask

    task automatic drive_bit(input int sel, input logic v, input int n);
        rxd_m[sel] = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame, LSB first. A low final stop bit is released early so the
    // receiver's re-armed start detector sees only a short glitch.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit use_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops);
        drive_bit(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], BIT_CLKS);
        if (use_par) drive_bit(sel, par_bit, BIT_CLKS);
        for (int i = 0; i < nstop; i++) begin
            if ((i == nstop - 1) && (stops[i] == 1'b0)) begin
                drive_bit(sel, 1'b0, 20);
                drive_bit(sel, 1'b1, 12);
            end else begin
                drive_bit(sel, stops[i], BIT_CLKS);
            end
        end
    endtask

    task automatic wait_valid(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dv_m[sel] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic read_out(input int sel);
        rd_m[sel] = 1'b1;
        @(negedge clk);
        rd_m[sel] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (dout_m[s] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_dout[%0d]: got %h want 00", s, dout_m[s]);
            end
            vectors++;
            if ({dv_m[s], fe_m[s], pe_m[s], ov_m[s], busy_m[s]} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_status[%0d]: got v/fe/pe/ov/busy=%b%b%b%b%b want 00000",
                         s, dv_m[s], fe_m[s], pe_m[s], ov_m[s], busy_m[s]);
            end
        end
        rst = 1'b0;
        idle(8);
    endtask

    task automatic test_basic();
        bit   ok;
        exp_t e;
        align();
        exp_q.push_back(exp_t'{8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01);
        wait_valid(0, 64, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_timeout: dout_valid got 0 want 1");
        end
        e = exp_q.pop_front();
        vectors++;
        if ({dout_m[0], fe_m[0], pe_m[0]} !== {e.data, e.ferr, e.perr}) begin
            miscompares++;
            $display("FAIL basic_char: got %h fe=%b pe=%b want %h fe=%b pe=%b",
                     dout_m[0], fe_m[0], pe_m[0], e.data, e.ferr, e.perr);
        end
        idle(40);
        vectors++;
        if (dv_m[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_hold: dout_valid got %b want 1", dv_m[0]);
        end
        read_out(0);
        vectors++;
        if (dv_m[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_read: dout_valid got %b want 0", dv_m[0]);
        end
        vectors++;
        if (dout_m[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_retain: dout got %h want a5", dout_m[0]);
        end
        idle(20);
    endtask

    task automatic test_false_start();
        align();
        drive_bit(0, 1'b0, 8);
        vectors++;
        if (busy_m[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy: busy got %b want 1", busy_m[0]);
        end
        drive_bit(0, 1'b1, 64);
        vectors++;
        if (busy_m[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_idle: busy got %b want 0", busy_m[0]);
        end
        vectors++;
        if (dv_m[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_valid: dout_valid got %b want 0", dv_m[0]);
        end
    endtask

    task automatic test_parity();
        bit   ok;
        exp_t e;
        // 0x07 has three ones: even parity bit 1 is correct, 0 is wrong.
        for (int k = 0; k < 2; k++) begin
            align();
            exp_q.push_back(exp_t'{8'h07, 1'b0, (k == 1)});
            send_frame(1, 8'h07, 1'b1, (k == 0), 1, 2'b01);
            wait_valid(1, 64, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL parity_timeout[%0d]: dout_valid got 0 want 1", k);
            end
            e = exp_q.pop_front();
            vectors++;
            if ({dout_m[1], fe_m[1], pe_m[1]} !== {e.data, e.ferr, e.perr}) begin
                miscompares++;
                $display("FAIL parity_char[%0d]: got %h fe=%b pe=%b want %h fe=%b pe=%b",
                         k, dout_m[1], fe_m[1], pe_m[1], e.data, e.ferr, e.perr);
            end
            read_out(1);
            idle(20);
        end
    endtask

    task automatic test_frame();
        bit   ok;
        exp_t e;
        int   base;
        base = ov_cnt[0];
        align();
        exp_q.push_back(exp_t'{8'h3C, 1'b1, 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b00);
        wait_valid(0, 64, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL frame_timeout: dout_valid got 0 want 1");
        end
        e = exp_q.pop_front();
        vectors++;
        if ({dout_m[0], fe_m[0], pe_m[0]} !== {e.data, e.ferr, e.perr}) begin
            miscompares++;
            $display("FAIL frame_char: got %h fe=%b pe=%b want %h fe=%b pe=%b",
                     dout_m[0], fe_m[0], pe_m[0], e.data, e.ferr, e.perr);
        end
        idle(64);
        vectors++;
        if ({busy_m[0], ov_cnt[0] - base} !== {1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL frame_after: busy=%b overruns=%0d want busy=0 overruns=0",
                     busy_m[0], ov_cnt[0] - base);
        end
        read_out(0);
        idle(20);
    endtask

    task automatic test_stop2();
        bit   ok;
        exp_t e;
        // stops[0] is the first stop bit on the line.
        for (int k = 0; k < 2; k++) begin
            align();
            exp_q.push_back(exp_t'{8'h5A, (k == 1), 1'b0});
            send_frame(2, 8'h5A, 1'b0, 1'b0, 2, (k == 0) ? 2'b11 : 2'b01);
            wait_valid(2, 64, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL stop2_timeout[%0d]: dout_valid got 0 want 1", k);
            end
            e = exp_q.pop_front();
            vectors++;
            if ({dout_m[2], fe_m[2], pe_m[2]} !== {e.data, e.ferr, e.perr}) begin
                miscompares++;
                $display("FAIL stop2_char[%0d]: got %h fe=%b pe=%b want %h fe=%b pe=%b",
                         k, dout_m[2], fe_m[2], pe_m[2], e.data, e.ferr, e.perr);
            end
            idle(64);
            read_out(2);
            idle(20);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          base;
        int unsigned s1;
        int unsigned s2;
        int unsigned offset;
        int unsigned target;
        bit          hit;

        // Nobody reads: the second character must be dropped with one pulse.
        base = ov_cnt[0];
        align();
        s1 = cyc;
        exp_q.push_back(exp_t'{8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
        idle(4);
        e = exp_q.pop_front();
        vectors++;
        if ({dout_m[0], dv_m[0], fe_m[0]} !== {e.data, 1'b1, e.ferr}) begin
            miscompares++;
            $display("FAIL b2b_keep: got %h v=%b fe=%b want %h v=1 fe=%b",
                     dout_m[0], dv_m[0], fe_m[0], e.data, e.ferr);
        end
        vectors++;
        if (ov_cnt[0] - base !== 1) begin
            miscompares++;
            $display("FAIL b2b_overrun: overrun cycles got %0d want 1", ov_cnt[0] - base);
        end
        // Overrun is registered at the delivery edge; reuse that timing.
        offset = ov_cyc[0] - s1;
        read_out(0);
        idle(40);

        // Same frames, rd_ready high exactly on the second delivery cycle.
        base = ov_cnt[0];
        align();
        s2 = cyc;
        target = s2 + offset - 1;
        exp_q.push_back(exp_t'{8'h11, 1'b0, 1'b0});
        exp_q.push_back(exp_t'{8'h22, 1'b0, 1'b0});
        fork
            begin
                send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
                send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
            end
            begin
                hit = 1'b0;
                for (int i = 0; i < 800; i++) begin
                    if (cyc == target) begin
                        hit = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                vectors++;
                if (!hit) begin
                    miscompares++;
                    $display("FAIL b2b_sync: delivery cycle %0d not reached", target);
                end
                e = exp_q.pop_front();
                vectors++;
                if ({dout_m[0], dv_m[0]} !== {e.data, 1'b1}) begin
                    miscompares++;
                    $display("FAIL b2b_first: got %h v=%b want %h v=1", dout_m[0], dv_m[0], e.data);
                end
                rd_m[0] = 1'b1;
                @(negedge clk);
                rd_m[0] = 1'b0;
            end
        join
        idle(4);
        e = exp_q.pop_front();
        vectors++;
        if ({dout_m[0], dv_m[0], fe_m[0]} !== {e.data, 1'b1, e.ferr}) begin
            miscompares++;
            $display("FAIL b2b_swap: got %h v=%b fe=%b want %h v=1 fe=%b",
                     dout_m[0], dv_m[0], fe_m[0], e.data, e.ferr);
        end
        vectors++;
        if (ov_cnt[0] - base !== 0) begin
            miscompares++;
            $display("FAIL b2b_no_overrun: overrun cycles got %0d want 0", ov_cnt[0] - base);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        // 0x22 is still held from the previous test; start 0x55 and cut it.
        align();
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b1, 16);
        vectors++;
        if ({busy_m[0], dv_m[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_pre: busy=%b v=%b want busy=1 v=1", busy_m[0], dv_m[0]);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (dout_m[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_dout: got %h want 00", dout_m[0]);
        end
        vectors++;
        if ({dv_m[0], fe_m[0], pe_m[0], ov_m[0], busy_m[0]} !== 5'b00000) begin
            miscompares++;
            $display("FAIL rstmid_status: got v/fe/pe/ov/busy=%b%b%b%b%b want 00000",
                     dv_m[0], fe_m[0], pe_m[0], ov_m[0], busy_m[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_bit(0, 1'b1, 10 * BIT_CLKS);
        vectors++;
        if ({dv_m[0], busy_m[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_abandon: v=%b busy=%b want 0 0", dv_m[0], busy_m[0]);
        end
        align();
        exp_q.push_back(exp_t'{8'h81, 1'b0, 1'b0});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b01);
        wait_valid(0, 64, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstmid_timeout: dout_valid got 0 want 1");
        end
        e = exp_q.pop_front();
        vectors++;
        if ({dout_m[0], fe_m[0], pe_m[0]} !== {e.data, e.ferr, e.perr}) begin
            miscompares++;
            $display("FAIL rstmid_char: got %h fe=%b pe=%b want %h fe=%b pe=%b",
                     dout_m[0], fe_m[0], pe_m[0], e.data, e.ferr, e.perr);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxd_m[i] = 1'b1;
            rd_m[i]  = 1'b0;
        end
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_frame();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
